// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - fixed-period servo PWM generator with frame-aligned duty and enable (option macro: SERVO_PWM_CLAMP_EN)
module servo_pwm_gen #(
    parameter int PERIOD_CLKS = 1000000,
    parameter int MIN_CLKS    = 25000,
    parameter int MAX_CLKS    = 125000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEn,
    input  logic [31:0] iDuty,
    output logic        oPwm,
    output logic        oFrame,
    output logic        oActive,
    output logic [31:0] oDuty,
    output logic        oClamp
);

    localparam int CW = $clog2(PERIOD_CLKS);
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CLKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [31:0]   dutyQ, dutyNext, loadDuty;
    logic          clampHit, clampNext, activeNext;

    // Reject parameter sets that would make the period or pulse limits meaningless
    if (PERIOD_CLKS < 2 || MIN_CLKS > MAX_CLKS || MAX_CLKS >= PERIOD_CLKS) begin : gBadParams
        $error("servo_pwm_gen: illegal PERIOD_CLKS/MIN_CLKS/MAX_CLKS combination");
    end

`ifdef SERVO_PWM_CLAMP_EN
    // Saturate the incoming duty into the servo's legal pulse range
    always_comb begin
        loadDuty = iDuty;
        clampHit = 1'b0;
        if (iDuty < 32'(MIN_CLKS)) begin
            loadDuty = 32'(MIN_CLKS);
            clampHit = 1'b1;
        end else if (iDuty > 32'(MAX_CLKS)) begin
            loadDuty = 32'(MAX_CLKS);
            clampHit = 1'b1;
        end
    end
`else
    assign loadDuty = iDuty;
    assign clampHit = 1'b0;
`endif

    // Next-state: duty only reloads on enable or at a period wrap, so pulses are never cut or stretched
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        dutyNext  = dutyQ;
        clampNext = 1'b0;
        case (state)
            IDLE: begin
                cntNext = '0;
                if (iEn) begin
                    stateNext = RUN;
                    dutyNext  = loadDuty;
                    clampNext = clampHit;
                end
            end
            RUN, DRAIN: begin
                if (cnt == LAST) begin
                    cntNext = '0;
                    if (iEn) begin
                        stateNext = RUN;
                        dutyNext  = loadDuty;
                        clampNext = clampHit;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    cntNext   = cnt + 1'b1;
                    stateNext = iEn ? RUN : DRAIN;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
        activeNext = (stateNext != IDLE);
    end

    // State, counter, shadow duty and outputs registered from next-state values so oPwm is glitch-free
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            cnt     <= '0;
            dutyQ   <= '0;
            oPwm    <= 1'b0;
            oFrame  <= 1'b0;
            oActive <= 1'b0;
            oClamp  <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            dutyQ   <= dutyNext;
            oPwm    <= activeNext && (32'(cntNext) < dutyNext);
            oFrame  <= activeNext && (cntNext == '0);
            oActive <= activeNext;
            oClamp  <= clampNext;
        end
    end

    assign oDuty = dutyQ;

endmodule
